button_bank: RTL
================

# button_bank

Parametrised multi-channel debouncer for front-panel buttons and switches, the successor to the single-channel debouncer. It synchronises `CHANNELS` raw asynchronous inputs and debounces them against one shared sample tick. For each channel it produces level, press/release edge pulses, a long-press pulse and an auto-repeat pulse train. It sits between the board pins and the game/menu control FSMs, which consume only single-cycle pulses.

## Interface
- `CHANNELS`, 5: number of independent inputs.
- `SAMPLE_CYCLES`, 100000: clk cycles per sample tick (1 ms at 100 MHz); ≥2.
- `STABLE_SAMPLES`, 20: consecutive differing samples required to change debounced state; ≥1.
- `LONG_SAMPLES`, 1000: ticks of continuous hold before `long_press`; 0 disables long-press and repeat.
- `REPEAT_SAMPLES`, 200: ticks between `repeat_pulse` after long press; ≥1.
- `ACTIVE_LOW`, 0: 1 inverts raw inputs, so pressed = pin low.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `button`  in  CHANNELS  raw asynchronous inputs.
- `hold`  out  CHANNELS  debounced level, 1 = pressed.
- `pressed`  out  CHANNELS  1-cycle pulse on debounced 0→1.
- `released`  out  CHANNELS  1-cycle pulse on debounced 1→0.
- `long_press`  out  CHANNELS  1-cycle pulse when hold duration reaches `LONG_SAMPLES` ticks.
- `repeat_pulse`  out  CHANNELS  1-cycle pulse every `REPEAT_SAMPLES` ticks after `long_press` while held.
- `any_pressed`  out  1  OR of `pressed`.

## Operation
**Input conditioning**
- Each channel passes through a 2-flop synchroniser, then XOR with `ACTIVE_LOW`, giving `sync[i]`.

**Shared tick**
- A down-counter of width `$clog2(SAMPLE_CYCLES)` reloads with `SAMPLE_CYCLES-1` on reset and whenever it equals 0.
- `tick` is high for exactly the one cycle the counter equals 0.

**Debounce (per channel), on tick only**
- If `sync != hold`: increment the stable counter. When the incremented value equals `STABLE_SAMPLES`, set `hold <= sync` and clear the counter.
- If `sync == hold`: clear the counter. A single agreeing sample therefore restarts qualification.
- The counter width is `$clog2(STABLE_SAMPLES+1)`.

**Edge pulses**
- `hold_d` registers `hold` every clk.
- `pressed = hold & ~hold_d`.
- `released = ~hold & hold_d`.

**Long-press and repeat (per channel)**
- States: IDLE, HELD, LONG.
- IDLE → HELD on the `hold` rise, with `hcnt = 0`.
- In HELD, each tick increments `hcnt`. When `hcnt` reaches `LONG_SAMPLES`, pulse `long_press`, go to LONG and clear `rcnt`.
- In LONG, each tick increments `rcnt`. When `rcnt` reaches `REPEAT_SAMPLES`, pulse `repeat_pulse` and clear `rcnt`.
- Any state → IDLE when `hold` = 0; counters are cleared.
- `long_press` and `repeat_pulse` are registered and are high in the cycle after the qualifying tick.
- When `LONG_SAMPLES` = 0, the FSM stays in IDLE, and `long_press` and `repeat_pulse` are constant 0.

## Timing
- **Reset values:** on reset, all outputs, `hold`, `hold_d`, synchronisers, all counters and FSMs are 0/IDLE. A button held through reset yields `pressed` once qualification completes after reset release.
- **Press latency:** latency from a clean raw edge to the `hold` change is 2 clk plus `STABLE_SAMPLES` ticks, with the first sample arriving after 0..`SAMPLE_CYCLES-1` clk. `pressed`/`released` are coincident with the `hold` change.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels pulse in the same cycle.
- **Release edge cases:**
  - Release on the same tick that `long_press` would fire: `released` wins, and no `long_press` fires.
  - Release in LONG: `released` only, no further `repeat_pulse`.
- **Reset mid-operation:** reset during a hold drops `hold` without a `released` pulse.
- **No pulse without a transition:** no pulse output may be high for two consecutive cycles, and no pulse may occur without a preceding qualifying transition.

## Test plan
Parameters for the bench: `CHANNELS=2`, `SAMPLE_CYCLES=4`, `STABLE_SAMPLES=3`, `LONG_SAMPLES=8`, `REPEAT_SAMPLES=4`.
- **Clean press:** `button[0]` 0→1 held → `hold[0]` rises 3 ticks after `sync` goes high; `pressed[0]` high exactly 1 cycle; `any_pressed` matches; channel 1 unaffected.
- **Glitch rejection:** `button[0]` high for 6 clk then low → `hold`, `pressed` and `released` stay 0.
- **Bounce then settle:** toggle every 2 clk for 40 clk, then hold 1 → exactly one `pressed`; no `released` until the input returns low for ≥3 ticks.
- **Long press and repeat:** hold 60 ticks → `long_press` once, 8 ticks after the `hold` rise; `repeat_pulse` at 12, 16, 20… ticks after the rise; release → `released` and the pulse trains stop.
- **Simultaneous channels:** both channels pressed on the same clk → `pressed[1:0]=2'b11` in the same cycle; `any_pressed` high 1 cycle.
- **Reset mid-hold:** assert reset while `hold[0]=1` → all outputs 0 the next cycle, no `released`; the button still held → `pressed[0]` again after 3 ticks.

Source files
------------

// File: rtl/button_bank.sv
// rtl/button_bank.sv - multi-channel button debouncer with edge, long-press and auto-repeat pulses
//
// Synchronises CHANNELS raw inputs and debounces each of them against one shared
// sample tick. Per channel it produces the debounced level plus single-cycle
// press, release, long-press and auto-repeat pulses.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high
//   button        raw asynchronous inputs, one bit per channel
//   hold          debounced level, 1 = pressed
//   pressed       1-cycle pulse on debounced 0->1
//   released      1-cycle pulse on debounced 1->0
//   long_press    1-cycle pulse once the hold lasts LONG_SAMPLES ticks
//   repeat_pulse  1-cycle pulse every REPEAT_SAMPLES ticks after long_press
//   any_pressed   OR of pressed

module button_bank #(
    parameter int CHANNELS       = 5,
    parameter int SAMPLE_CYCLES  = 100000,
    parameter int STABLE_SAMPLES = 20,
    parameter int LONG_SAMPLES   = 1000,
    parameter int REPEAT_SAMPLES = 200,
    parameter int ACTIVE_LOW     = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] button,
    output logic [CHANNELS-1:0] hold,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] released,
    output logic [CHANNELS-1:0] long_press,
    output logic [CHANNELS-1:0] repeat_pulse,
    output logic                any_pressed
);

    localparam int TW = $clog2(SAMPLE_CYCLES);
    localparam int SW = $clog2(STABLE_SAMPLES + 1);
    localparam int HW = (LONG_SAMPLES > 0) ? $clog2(LONG_SAMPLES + 1) : 1;
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);

    localparam logic [TW-1:0] TICK_RELOAD = TW'(SAMPLE_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_L    = SW'(STABLE_SAMPLES);
    localparam logic [HW-1:0] LONG_L      = HW'(LONG_SAMPLES);
    localparam logic [RW-1:0] REPEAT_L    = RW'(REPEAT_SAMPLES);
    localparam logic          INVERT      = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_t;

    // ------------------------------------------------------------------
    // Input synchroniser and polarity
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] sync_meta;
    logic [CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= button;
            sync_q    <= sync_meta;
        end
    end

    assign sync = sync_q ^ {CHANNELS{INVERT}};

    // ------------------------------------------------------------------
    // Shared sample tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= TICK_RELOAD;
        end else begin
            tick_cnt <= tick_cnt - TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] hold_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_d <= '0;
        end else begin
            hold_d <= hold;
        end
    end

    assign pressed     = hold & ~hold_d;
    assign released    = ~hold & hold_d;
    assign any_pressed = |pressed;

    // ------------------------------------------------------------------
    // Per-channel debounce and long-press / repeat FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        logic [SW-1:0] scnt;
        logic [SW-1:0] scnt_inc;
        logic          hold_bit;
        logic          qualify;

        assign scnt_inc = scnt + SW'(1);
        // This tick completes qualification and flips the debounced level.
        assign qualify  = tick && (sync[i] != hold_bit) && (scnt_inc == STABLE_L);
        assign hold[i]  = hold_bit;

        always_ff @(posedge clk) begin
            if (reset) begin
                scnt     <= '0;
                hold_bit <= 1'b0;
            end else if (tick) begin
                if (sync[i] != hold_bit) begin
                    if (scnt_inc == STABLE_L) begin
                        hold_bit <= sync[i];
                        scnt     <= '0;
                    end else begin
                        scnt     <= scnt_inc;
                    end
                end else begin
                    scnt <= '0;
                end
            end
        end

        if (LONG_SAMPLES > 0) begin : gen_long
            state_t        state;
            state_t        state_n;
            logic [HW-1:0] hcnt;
            logic [HW-1:0] hcnt_n;
            logic [HW-1:0] hcnt_inc;
            logic [RW-1:0] rcnt;
            logic [RW-1:0] rcnt_n;
            logic [RW-1:0] rcnt_inc;
            logic          lp_q;
            logic          lp_n;
            logic          rp_q;
            logic          rp_n;
            logic          fall_now;

            assign hcnt_inc = hcnt + HW'(1);
            assign rcnt_inc = rcnt + RW'(1);
            // A release qualifying on this very tick must suppress any pulse
            // the same tick would otherwise produce.
            assign fall_now = qualify && hold_bit;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state <= ST_IDLE;
                    hcnt  <= '0;
                    rcnt  <= '0;
                    lp_q  <= 1'b0;
                    rp_q  <= 1'b0;
                end else begin
                    state <= state_n;
                    hcnt  <= hcnt_n;
                    rcnt  <= rcnt_n;
                    lp_q  <= lp_n;
                    rp_q  <= rp_n;
                end
            end

            always_comb begin
                state_n = state;
                hcnt_n  = hcnt;
                rcnt_n  = rcnt;
                lp_n    = 1'b0;
                rp_n    = 1'b0;
                if (!hold_bit || fall_now) begin
                    state_n = ST_IDLE;
                    hcnt_n  = '0;
                    rcnt_n  = '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            state_n = ST_HELD;
                            hcnt_n  = '0;
                        end
                        ST_HELD: begin
                            if (tick) begin
                                if (hcnt_inc == LONG_L) begin
                                    lp_n    = 1'b1;
                                    state_n = ST_LONG;
                                    rcnt_n  = '0;
                                end else begin
                                    hcnt_n  = hcnt_inc;
                                end
                            end
                        end
                        ST_LONG: begin
                            if (tick) begin
                                if (rcnt_inc == REPEAT_L) begin
                                    rp_n   = 1'b1;
                                    rcnt_n = '0;
                                end else begin
                                    rcnt_n = rcnt_inc;
                                end
                            end
                        end
                        default: begin
                            state_n = ST_IDLE;
                            hcnt_n  = '0;
                            rcnt_n  = '0;
                        end
                    endcase
                end
            end

            assign long_press[i]   = lp_q;
            assign repeat_pulse[i] = rp_q;
        end else begin : gen_nolong
            assign long_press[i]   = 1'b0;
            assign repeat_pulse[i] = 1'b0;
        end
    end

endmodule
